// File: rtl/param_stream_sorter.sv
// param_stream_sorter: loads N words, sorts them by odd-even transposition, then streams them out in sorted order.
// The extra SORT cycle at phase index N only hands over to OUT. This gives the N+1 cycle load-to-output latency.
module param_stream_sorter #(
  parameter int W  = 4,
  parameter int N  = 8,
  parameter int CW = $clog2(N+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         descend,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);
  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [W-1:0]  a_q [N];
  logic [W-1:0]  a_d [N];
  logic [W-1:0]  rd;
  logic          in_fire, out_fire;
  assign in_ready  = state_q == LOAD;
  assign out_valid = state_q == OUT;
  assign busy      = state_q != LOAD;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? rd : '0;
  assign out_last  = out_valid && cnt_q == CW'(N-1);
  always_comb begin
    rd = '0;
    for (int i = 0; i < N; i++)
      if (cnt_q == CW'(i)) rd = a_q[i];
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_d     = a_q;
    case (state_q)
      LOAD: if (in_fire) begin
        for (int i = 0; i < N; i++)
          if (cnt_q == CW'(i)) a_d[i] = in_data;
        cnt_d   = cnt_q == CW'(N-1) ? '0 : cnt_q + 1'b1;
        mode_d  = cnt_q == CW'(N-1) ? descend : mode_q;
        state_d = cnt_q == CW'(N-1) ? SORT : LOAD;
      end
      SORT: if (cnt_q == CW'(N)) begin
        cnt_d   = '0;
        state_d = OUT;
      end else begin
        // Pairs within a phase are disjoint, so every exchange can read the old array.
        for (int i = 0; i < N-1; i++)
          if (i[0] == cnt_q[0] && (mode_q ? a_q[i] < a_q[i+1] : a_q[i] > a_q[i+1])) begin
            a_d[i]   = a_q[i+1];
            a_d[i+1] = a_q[i];
          end
        cnt_d = cnt_q + 1'b1;
      end
      OUT: if (out_fire) begin
        cnt_d   = out_last ? '0 : cnt_q + 1'b1;
        state_d = out_last ? LOAD : OUT;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      a_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
    end
endmodule

// File: tb/tb_param_stream_sorter.sv
// tb_param_stream_sorter: directed batches with a queue scoreboard checked by an output monitor.
module tb_param_stream_sorter;
  logic       clk = 0, rst = 1;
  logic       in_valid = 0, in_ready, descend = 0;
  logic [3:0] in_data = 0, out_data;
  logic       out_valid, out_ready = 1, out_last, busy;
  int         total = 0, passed = 0, cyc = 0, accept_cyc = 0;
  bit         lat_pending = 0, prev_stall = 0, prev_last;
  logic [3:0] prev_data;
  logic [4:0] q[$];
  logic [4:0] e;
  bit         pat[6] = '{1, 0, 0, 1, 0, 1};

  param_stream_sorter #(.W(4), .N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .descend(descend), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  always @(negedge clk) if (!rst) begin
    if (lat_pending && out_valid) begin
      chk("latency", cyc - accept_cyc, 9);
      lat_pending = 0;
    end
    if (prev_stall && out_valid) begin
      chk("stall_data", out_data, prev_data);
      chk("stall_last", out_last, prev_last);
    end
    if (out_valid) begin
      chk("in_ready_during_out", in_ready, 0);
      chk("busy_during_out", busy, 1);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = q.pop_front();
        chk("out_data", out_data, e[3:0]);
        chk("out_last", out_last, e[4]);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  task automatic push_exp(input logic [3:0] x[8]);
    for (int i = 0; i < 8; i++) q.push_back({i == 7, x[i]});
  endtask

  task automatic send(input logic [3:0] w[8], input logic [7:0] dsel, input bit gap);
    bit ok;
    for (int i = 0; i < 8; i++) begin
      if (gap && $urandom_range(0, 1) == 1) begin
        in_valid = 0;
        @(posedge clk); #1;
      end
      in_valid = 1; in_data = w[i]; descend = dsel[i];
      ok = 0;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk); ok = in_ready;
        @(posedge clk); #1;
      end
      if (!ok) chk("accept_timeout", 0, 1);
    end
    accept_cyc = cyc; lat_pending = 1;
    in_valid = 0; descend = ~dsel[7];
  endtask

  task automatic drain(input bit bp);
    out_ready = 1;
    for (int c = 0; c < 300 && q.size() != 0; c++) begin
      @(posedge clk); #1;
      out_ready = bp ? pat[c % 6] : 1'b1;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    out_ready = 1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1; #1;
    chk_reset_outs(tag);
    q.delete(); lat_pending = 0; prev_stall = 0;
    #2 rst = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 chk_reset_outs("reset");
    #12 rst = 0;
    @(posedge clk); #1;
    push_exp('{0, 1, 2, 3, 7, 8, 9, 15});
    send('{7, 3, 9, 1, 15, 0, 8, 2}, 8'h00, 0);
    drain(0);
    push_exp('{15, 9, 8, 7, 3, 2, 1, 0});
    send('{7, 3, 9, 1, 15, 0, 8, 2}, 8'b1010_1010, 0);
    drain(0);
    push_exp('{0, 1, 2, 3, 7, 8, 9, 15});
    send('{7, 3, 9, 1, 15, 0, 8, 2}, 8'b0111_1111, 0);
    drain(0);
    push_exp('{0, 0, 5, 5, 5, 5, 15, 15});
    send('{5, 5, 0, 15, 5, 0, 15, 5}, 8'h00, 0);
    drain(0);
    push_exp('{1, 2, 3, 4, 5, 6, 7, 8});
    send('{1, 2, 3, 4, 5, 6, 7, 8}, 8'h00, 0);
    drain(0);
    push_exp('{8, 9, 10, 11, 12, 13, 14, 15});
    send('{15, 14, 13, 12, 11, 10, 9, 8}, 8'h00, 0);
    drain(0);
    push_exp('{0, 3, 4, 4, 6, 9, 11, 12});
    send('{12, 4, 4, 9, 0, 3, 11, 6}, 8'h00, 0);
    drain(1);
    push_exp('{14, 13, 10, 9, 6, 5, 2, 1});
    send('{10, 2, 14, 6, 1, 13, 5, 9}, 8'h80, 1);
    in_valid = 1; in_data = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("in_ready_after_load", in_ready, 0);
      chk("busy_after_load", busy, 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
    drain(0);
    send('{3, 1, 2, 0, 7, 6, 5, 4}, 8'h00, 0);
    repeat (3) @(posedge clk);
    #1 chk("busy_mid_sort", busy, 1);
    do_reset("abort_sort");
    push_exp('{1, 2, 3, 4, 6, 7, 8, 9});
    out_ready = 0;
    send('{9, 1, 8, 2, 7, 3, 6, 4}, 8'h00, 0);
    for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
    @(posedge clk); #1 out_ready = 1;
    repeat (4) @(posedge clk);
    #1 out_ready = 0;
    repeat (2) @(posedge clk);
    #1 chk("stalled_r4_data", out_data, 6);
    do_reset("abort_out");
    out_ready = 1;
    push_exp('{1, 2, 3, 4, 5, 6, 7, 8});
    send('{4, 3, 2, 1, 8, 7, 6, 5}, 8'h00, 0);
    drain(0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
